// File: rtl/add_sub_arbiter_pkg.sv
// Shared types and constants for the add/sub arbiter slice.
package add_sub_arbiter_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NUM_REQ = 4;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   // Keeps the id field at least one bit wide for tiny requester counts.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/add_sub_arbiter_if.sv
// Requester and result channels of the shared add/sub arbiter.
interface add_sub_arbiter_if
   import add_sub_arbiter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_REQ = DEF_NUM_REQ
);
   localparam int ID_W = clog2_min1(NUM_REQ);

   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_in0;
   logic [NUM_REQ-1:0][WIDTH-1:0] req_in1;
   logic [NUM_REQ-1:0]            req_sel;
   logic                          out_valid;
   logic                          out_ready;
   logic [WIDTH-1:0]              out_data;
   logic [ID_W-1:0]               out_id;

   modport master (
      output req_valid, req_in0, req_in1, req_sel, out_ready,
      input  req_ready, out_valid, out_data, out_id
   );

   modport slave (
      input  req_valid, req_in0, req_in1, req_sel, out_ready,
      output req_ready, out_valid, out_data, out_id
   );

endinterface

// File: rtl/add_sub_arbiter_pipe.sv
// Two-stage registered add/sub with valid and id carried alongside the data.
module add_sub_pipe
   import add_sub_arbiter_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   input  logic [ID_W-1:0]  in_id,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  op_t              in_op,
   output logic             out_valid,
   output logic [ID_W-1:0]  out_id,
   output logic [WIDTH-1:0] out_data
);

   logic             s1_valid;
   logic [ID_W-1:0]  s1_id;
   logic [WIDTH-1:0] s1_in0;
   logic [WIDTH-1:0] s1_in1;
   op_t              s1_op;
   logic             s1_sub;
   logic [WIDTH-1:0] s1_result;

   // Subtraction as in0 + ~in1 + 1 keeps a single carry chain for both ops.
   assign s1_sub    = (s1_op == OP_SUB);
   assign s1_result = s1_in0 + (s1_in1 ^ {WIDTH{s1_sub}}) + {{(WIDTH-1){1'b0}}, s1_sub};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_id     <= '0;
         s1_in0    <= '0;
         s1_in1    <= '0;
         s1_op     <= OP_ADD;
         out_valid <= 1'b0;
         out_id    <= '0;
         out_data  <= '0;
      end else if (en) begin
         s1_valid  <= in_valid;
         s1_id     <= in_id;
         s1_in0    <= in0;
         s1_in1    <= in1;
         s1_op     <= in_op;
         out_valid <= s1_valid;
         out_id    <= s1_id;
         out_data  <= s1_result;
      end
   end

endmodule

// File: rtl/add_sub_arbiter.sv
// Arbitrates NUM_REQ requesters onto one pipelined add/sub unit.
// Define ADD_SUB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module add_sub_arbiter
   import add_sub_arbiter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_REQ = DEF_NUM_REQ
) (
   input logic              clk,
   input logic              rst_n,
   add_sub_arbiter_if.slave bus
);

   localparam int ID_W = clog2_min1(NUM_REQ);

   logic            en;
   logic            any_valid;
   logic [ID_W-1:0] grant_id;

   assign en        = !bus.out_valid || bus.out_ready;
   assign any_valid = |bus.req_valid;

`ifdef ADD_SUB_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] cand;
   logic            found;

   // Scan from the pointer and wrap; the first pending requester wins.
   always_comb begin
      grant_id = '0;
      cand     = '0;
      found    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = ID_W'((int'(ptr) + k) % NUM_REQ);
         if (!found && bus.req_valid[cand]) begin
            found    = 1'b1;
            grant_id = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (en && any_valid) begin
         ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
   end
`else
   always_comb begin
      grant_id = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (bus.req_valid[k]) begin
            grant_id = ID_W'(k);
         end
      end
   end
`endif

   always_comb begin
      bus.req_ready = '0;
      if (en && any_valid) begin
         bus.req_ready[grant_id] = 1'b1;
      end
   end

   add_sub_pipe #(
      .WIDTH (WIDTH),
      .ID_W  (ID_W)
   ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (any_valid),
      .in_id     (grant_id),
      .in0       (bus.req_in0[grant_id]),
      .in1       (bus.req_in1[grant_id]),
      .in_op     (op_t'(bus.req_sel[grant_id])),
      .out_valid (bus.out_valid),
      .out_id    (bus.out_id),
      .out_data  (bus.out_data)
   );

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Scoreboard bench for add_sub_arbiter; ADD_SUB_ARB_ROUND_ROBIN_EN selects the expected grant order.
module tb_add_sub_arbiter;
   import add_sub_arbiter_pkg::*;

   localparam int WIDTH   = 8;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   exp_t exp_q[$];
   exp_t mon_e;
   int   num_checks = 0;
   int   num_fails  = 0;

   always #5 clk = ~clk;

   add_sub_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

   add_sub_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_fails++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   function automatic void expect_result(input int id, input logic [WIDTH-1:0] data);
      exp_q.push_back('{id: ID_W'(id), data: data});
   endfunction

   // Every accepted result is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            num_checks++;
            num_fails++;
            $display("[TB] FAIL unexpected_output: actual id=%0d data=0x%0h required=none",
                     bus.out_id, bus.out_data);
         end else begin
            mon_e = exp_q.pop_front();
            check_output("out_id", 32'(bus.out_id), 32'(mon_e.id));
            check_output("out_data", 32'(bus.out_data), 32'(mon_e.data));
         end
      end
   end

   task automatic apply_stimulus(input int idx, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic s);
      bit done = 1'b0;
      bus.req_in0[idx]   = a;
      bus.req_in1[idx]   = b;
      bus.req_sel[idx]   = s;
      bus.req_valid[idx] = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge clk);
         if (bus.req_ready[idx]) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      bus.req_valid[idx] = 1'b0;
      if (!done) begin
         num_checks++;
         num_fails++;
         $display("[TB] FAIL handshake_timeout: actual=no transfer required=transfer on req %0d", idx);
      end
   endtask

   // Holds a request mask until n transfers have happened.
   task automatic run_mask(input logic [NUM_REQ-1:0] mask, input int n);
      int cnt = 0;
      bus.req_valid = mask;
      for (int c = 0; c < 200 && cnt < n; c++) begin
         @(negedge clk);
         if ((bus.req_valid & bus.req_ready) != '0) begin
            cnt++;
            if (cnt == n) begin
               @(posedge clk);
               #1;
            end
         end
      end
      bus.req_valid = '0;
      if (cnt != n) begin
         num_checks++;
         num_fails++;
         $display("[TB] FAIL mask_timeout: actual=%0d transfers required=%0d", cnt, n);
      end
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
   endtask

   localparam logic [WIDTH-1:0] TABLE_RES [NUM_REQ] = '{8'h11, 8'h22, 8'h33, 8'h44};

`ifdef ADD_SUB_ARB_ROUND_ROBIN_EN
   localparam int ALL_IDS  [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   localparam int ODD_IDS  [7] = '{1, 3, 1, 3, 0, 1, 3};
`else
   localparam int ALL_IDS  [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
   localparam int ODD_IDS  [7] = '{1, 1, 1, 1, 0, 0, 0};
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_in0   = '0;
      bus.req_in1   = '0;
      bus.req_sel   = '0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check_output("reset_out_valid", 32'(bus.out_valid), 0);
      check_output("reset_out_data", 32'(bus.out_data), 0);
      check_output("reset_out_id", 32'(bus.out_id), 0);
      check_output("reset_req_ready", 32'(bus.req_ready), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single subtract on requester 2 with explicit latency checks.
      expect_result(2, 8'h02);
      apply_stimulus(2, 8'd5, 8'd3, 1'b1);
      check_output("latency_t1_valid", 32'(bus.out_valid), 0);
      @(posedge clk);
      #1;
      check_output("latency_t2_valid", 32'(bus.out_valid), 1);
      check_output("latency_t2_data", 32'(bus.out_data), 32'h02);
      check_output("latency_t2_id", 32'(bus.out_id), 2);
      drain();

      // Wrap-around in both directions.
      expect_result(0, 8'hFF);
      apply_stimulus(0, 8'h00, 8'h01, 1'b1);
      expect_result(0, 8'h00);
      apply_stimulus(0, 8'hFF, 8'h01, 1'b0);
      drain();

      // Backpressure with a full pipeline.
      expect_result(1, 8'h10);
      expect_result(1, 8'hF0);
      expect_result(1, 8'h80);
      expect_result(1, 8'hFE);
      bus.out_ready = 1'b0;
      apply_stimulus(1, 8'h90, 8'h80, 1'b0);
      apply_stimulus(1, 8'h10, 8'h20, 1'b1);
      bus.req_in0[1]   = 8'h7F;
      bus.req_in1[1]   = 8'h01;
      bus.req_sel[1]   = 1'b0;
      bus.req_valid[1] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_output("stall_req_ready", 32'(bus.req_ready), 0);
         check_output("stall_out_valid", 32'(bus.out_valid), 1);
         check_output("stall_out_data", 32'(bus.out_data), 32'h10);
         check_output("stall_out_id", 32'(bus.out_id), 1);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      apply_stimulus(1, 8'h7F, 8'h01, 1'b0);
      apply_stimulus(1, 8'h03, 8'h05, 1'b1);
      drain();

      // Reset with two operations in flight; nothing may resurface.
      bus.out_ready = 1'b0;
      apply_stimulus(1, 8'h01, 8'h01, 1'b0);
      apply_stimulus(2, 8'h02, 8'h02, 1'b0);
      check_output("inflight_out_valid", 32'(bus.out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      check_output("async_reset_out_valid", 32'(bus.out_valid), 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_output("no_stale_out_valid", 32'(bus.out_valid), 0);
      end

      // Arbitration order with all requesters pending.
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.req_in0[i] = WIDTH'(8'h10 * (i + 1));
         bus.req_in1[i] = WIDTH'(i + 1);
         bus.req_sel[i] = 1'b0;
      end
      for (int i = 0; i < 8; i++) expect_result(ALL_IDS[i], TABLE_RES[ALL_IDS[i]]);
      @(posedge clk);
      #1;
      run_mask(4'b1111, 8);
      drain();

      // Requesters 1 and 3, then requester 0 joins.
      for (int i = 0; i < 7; i++) expect_result(ODD_IDS[i], TABLE_RES[ODD_IDS[i]]);
      run_mask(4'b1010, 4);
      run_mask(4'b1011, 3);
      drain();

      check_output("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
      $finish;
   end

endmodule
